// File: rtl/pwm_audio_out.sv
// PWM audio output stage.
// Takes unsigned samples through a valid/ready handshake into a one-entry holding
// buffer, loads the buffered sample (right-shifted by atten) as the PWM duty at every
// frame boundary, and drives a registered PWM bit. A frame is 2^WIDTH count ticks and
// a tick happens every DIV enabled clock cycles.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   ena           run enable; low freezes prescaler, counter and duty
//   sample_in     unsigned sample, WIDTH bits
//   sample_valid  sample_in valid this cycle
//   sample_ready  buffer can accept sample_in this cycle
//   atten         right-shift applied to the sample when it is loaded as duty
//   clr_underrun  synchronous clear of the underrun flag
//   pwm_out       registered PWM bit
//   frame_start   one-cycle pulse the cycle after each frame boundary
//   underrun      sticky: a boundary passed with the buffer empty
module pwm_audio_out #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [2:0]       atten,
    input  logic             clr_underrun,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             underrun
);

    localparam int unsigned     PscW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PscW-1:0] PscMax = PscW'(DIV - 1);

    logic [PscW-1:0]  psc_q, psc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] nbuf_q, nbuf_d;
    logic             nfull_q, nfull_d;
    logic             pwm_q, pwm_d;
    logic             fs_q, fs_d;
    logic             ur_q, ur_d;

    logic tick;
    logic boundary;
    logic transfer;

    // Ready is forced low during reset so nothing is accepted while the buffer clears.
    assign sample_ready = !nfull_q && !rst;

    assign tick     = ena && (psc_q == PscMax);
    assign boundary = tick && (cnt_q == '1);
    assign transfer = sample_valid && sample_ready;

    always_comb begin
        psc_d   = psc_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        nbuf_d  = nbuf_q;
        nfull_d = nfull_q;
        ur_d    = ur_q;

        if (ena) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A transfer can only happen while the buffer is empty, so it never collides
        // with the load below; a freed buffer refills from the next cycle on.
        if (transfer) begin
            nbuf_d  = sample_in;
            nfull_d = 1'b1;
        end
        if (boundary && nfull_q) begin
            duty_d  = nbuf_q >> atten;
            nfull_d = 1'b0;
        end

        // Set has priority over clear.
        if (clr_underrun) begin
            ur_d = 1'b0;
        end
        if (boundary && !nfull_q) begin
            ur_d = 1'b1;
        end

        fs_d  = boundary;
        pwm_d = ena && (cnt_q < duty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q   <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            nbuf_q  <= '0;
            nfull_q <= 1'b0;
            pwm_q   <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            psc_q   <= psc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            nbuf_q  <= nbuf_d;
            nfull_q <= nfull_d;
            pwm_q   <= pwm_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out. A queue models the one-entry sample buffer:
// accepted samples are pushed (already attenuated) and popped at each frame start to
// give the duty whose high-count the following frame must show.
module tb_pwm_audio_out;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [2:0] atten = '0;
    logic       clr_underrun = 1'b0;
    logic       pwm_out;
    logic       frame_start;
    logic       underrun;

    // Second instance with a prescaler of 4.
    logic       ena4 = 1'b1;
    logic [7:0] sample4 = '0;
    logic       valid4 = 1'b0;
    logic       ready4;
    logic [2:0] atten4 = '0;
    logic       clr4 = 1'b0;
    logic       pwm4;
    logic       fs4;
    logic       ur4;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];
    logic [7:0] model_duty = '0;

    always #5 clk = ~clk;

    pwm_audio_out #(.WIDTH(8), .DIV(1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .atten        (atten),
        .clr_underrun (clr_underrun),
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    pwm_audio_out #(.WIDTH(8), .DIV(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena4),
        .sample_in    (sample4),
        .sample_valid (valid4),
        .sample_ready (ready4),
        .atten        (atten4),
        .clr_underrun (clr4),
        .pwm_out      (pwm4),
        .frame_start  (fs4),
        .underrun     (ur4)
    );

    // Entered at a frame_start sample point; consumes exactly one frame and returns at
    // the next frame_start sample point. Optionally pushes a sample at offset 10 and
    // changes atten at offset 128.
    task automatic measure_frame(input string name, input bit do_push, input logic [7:0] pv,
                                 input bit chg, input logic [2:0] na);
        int hi;
        int fs_bad;
        logic [2:0] fa;
        if (exp_q.size() > 0) begin
            model_duty = exp_q.pop_front();
        end else begin
            checks++;
            if (underrun !== 1'b1) begin
                errors++;
                $display("FAIL %s_underrun: got %b expected 1", name, underrun);
            end
        end
        fa = chg ? na : atten;
        hi = 0;
        fs_bad = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) hi++;
            if (i < 256 && frame_start !== 1'b0) fs_bad++;
            if (do_push && i == 10) begin
                checks++;
                if (sample_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready: got %b expected 1", name, sample_ready);
                end
                sample_in = pv;
                sample_valid = 1'b1;
                exp_q.push_back(pv >> fa);
            end
            if (do_push && i == 11) sample_valid = 1'b0;
            if (chg && i == 128) atten = na;
        end
        checks++;
        if (hi !== int'(model_duty)) begin
            errors++;
            $display("FAIL %s_high: got %0d expected %0d", name, hi, model_duty);
        end
        checks++;
        if (fs_bad !== 0 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL %s_frame_start: stray %0d end %b expected 0 and 1", name, fs_bad,
                     frame_start);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm: got %b expected 0", pwm_out); end
        checks++;
        if (frame_start !== 1'b0) begin
            errors++; $display("FAIL rst_fs: got %b expected 0", frame_start);
        end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL rst_ur: got %b expected 0", underrun); end
        checks++;
        if (sample_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready: got %b expected 0", sample_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL rel_ready: got %b expected 1", sample_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        sample_in = 8'h40;
        sample_valid = 1'b1;
        exp_q.push_back(8'h40);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) sample_valid = 1'b0;
        end while (frame_start !== 1'b1 && n < 300);
        checks++;
        if (n !== 256) begin errors++; $display("FAIL first_boundary: got %0d expected 256", n); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL basic_ur: got %b expected 0", underrun); end
        measure_frame("basic_load", 1'b0, 8'h00, 1'b0, 3'd0);
        measure_frame("basic_repeat", 1'b0, 8'h00, 1'b0, 3'd0);
    endtask

    task automatic test_clear_underrun();
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL clr_ur: got %b expected 0", underrun); end
        repeat (254) @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got fs=%b ur=%b expected 1 1", frame_start, underrun);
        end
    endtask

    task automatic test_atten();
        atten = 3'd2;
        measure_frame("atten_repeat", 1'b1, 8'hFF, 1'b0, 3'd0);
        measure_frame("atten_hold", 1'b0, 8'h00, 1'b1, 3'd0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        logic [7:0] e;
        bit xfer;
        int hi, nx, rdy_bad, seen, n;
        s = 8'h10;
        sample_in = s;
        sample_valid = 1'b1;
        clr_underrun = 1'b1;
        xfer = (sample_ready === 1'b1);
        hi = 0; nx = 0; rdy_bad = 0; seen = 0; n = 0;
        while (seen < 4 && n < 1200) begin
            @(negedge clk);
            n++;
            clr_underrun = 1'b0;
            if (xfer) begin
                exp_q.push_back(s);
                nx++;
                s = s + 8'd1;
                sample_in = s;
            end
            if (pwm_out === 1'b1) hi++;
            if (frame_start === 1'b1) begin
                seen++;
                if (seen > 1) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    model_duty = e;
                    checks++;
                    if (hi !== int'(e)) begin
                        errors++;
                        $display("FAIL b2b_high: got %0d expected %0d", hi, e);
                    end
                end
                checks++;
                if (nx !== 1) begin errors++; $display("FAIL b2b_xfers: got %0d expected 1", nx); end
                if (seen == 4) sample_valid = 1'b0;
                xfer = (sample_ready === 1'b1) && sample_valid;
                hi = 0;
                nx = 0;
            end else begin
                if (sample_ready !== 1'b0) rdy_bad++;
                xfer = (sample_ready === 1'b1);
            end
        end
        checks++;
        if (seen !== 4) begin errors++; $display("FAIL b2b_timeout: got %0d expected 4", seen); end
        checks++;
        if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_ready: got %0d expected 0", rdy_bad); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_ur: got %b expected 0", underrun); end
    endtask

    task automatic test_underrun();
        measure_frame("ur_last", 1'b0, 8'h00, 1'b0, 3'd0);
        measure_frame("ur_repeat", 1'b0, 8'h00, 1'b0, 3'd0);
    endtask

    task automatic test_edges();
        measure_frame("edge_repeat", 1'b1, 8'h00, 1'b0, 3'd0);
        measure_frame("edge_zero", 1'b1, 8'hFF, 1'b0, 3'd0);
        measure_frame("edge_full", 1'b1, 8'hFF, 1'b0, 3'd0);
    endtask

    task automatic test_reset_mid();
        int n;
        if (exp_q.size() > 0) model_duty = exp_q.pop_front();
        sample_in = 8'h20;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (127) @(negedge clk);
        checks++;
        if (pwm_out !== 1'b1 || sample_ready !== 1'b0 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: got pwm=%b ready=%b ur=%b expected 1 0 1", pwm_out,
                     sample_ready, underrun);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (pwm_out !== 1'b0 || frame_start !== 1'b0 || underrun !== 1'b0 ||
            sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: got pwm=%b fs=%b ur=%b ready=%b expected 0 0 0 0", pwm_out,
                     frame_start, underrun, sample_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_duty = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 300);
        checks++;
        if (n !== 256) begin errors++; $display("FAIL post_rst_boundary: got %0d expected 256", n); end
        measure_frame("post_rst", 1'b0, 8'h00, 1'b0, 3'd0);
    endtask

    task automatic test_prescale();
        int n, hi, dis;
        logic [7:0] e;
        @(negedge clk);
        sample4 = 8'h40;
        valid4 = 1'b1;
        n = 0;
        while (ready4 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        exp4_q.push_back(8'h40);
        @(negedge clk);
        valid4 = 1'b0;
        n = 0;
        while (fs4 !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
        checks++;
        if (fs4 !== 1'b1) begin errors++; $display("FAIL div4_timeout: got %b expected 1", fs4); end
        for (int f = 0; f < 2; f++) begin
            e = exp4_q.pop_front();
            valid4 = 1'b1;
            sample4 = 8'h40;
            exp4_q.push_back(8'h40);
            n = 0; hi = 0; dis = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) valid4 = 1'b0;
                if (pwm4 === 1'b1) hi++;
                if (f == 1 && n > 100 && n <= 200 && pwm4 !== 1'b0) dis++;
                if (f == 1 && n == 100) ena4 = 1'b0;
                if (f == 1 && n == 200) ena4 = 1'b1;
            end while (fs4 !== 1'b1 && n < 1300);
            checks++;
            if (n !== (f == 1 ? 1124 : 1024)) begin
                errors++;
                $display("FAIL div4_len%0d: got %0d expected %0d", f, n, (f == 1 ? 1124 : 1024));
            end
            checks++;
            if (hi !== int'(e) * 4) begin
                errors++;
                $display("FAIL div4_high%0d: got %0d expected %0d", f, hi, int'(e) * 4);
            end
            if (f == 1) begin
                checks++;
                if (dis !== 0) begin errors++; $display("FAIL div4_dis: got %0d expected 0", dis); end
            end
        end
        exp4_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear_underrun();
        test_atten();
        test_back_to_back();
        test_underrun();
        test_edges();
        test_reset_mid();
        test_prescale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
